// File: rtl/imm_pkg.sv
// Shared encodings for the registered immediate extender: immsrc selects and
// skid-buffer FSM states.
package imm_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode from instr[31:7]; sign-extended to XLEN.
// Optional macro IMM_EXTEND_ZIMM_EN enables the CSR zimm (immsrc 101) decode.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]     instr,
    input  logic [2:0]      immsrc,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [31:0] imm32;
    logic        sign;

    // instr[k] of the full instruction lives at instr[k-7] here
    assign sign = instr[24];

    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (immsrc)
            IMM_I: imm32 = {{20{sign}}, instr[24:13]};
            IMM_S: imm32 = {{20{sign}}, instr[24:18], instr[4:0]};
            IMM_B: imm32 = {{20{sign}}, instr[0], instr[23:18], instr[4:1], 1'b0};
            IMM_J: imm32 = {{12{sign}}, instr[12:5], instr[13], instr[23:14], 1'b0};
            IMM_U: imm32 = {instr[24:5], 12'b0};
`ifdef IMM_EXTEND_ZIMM_EN
            IMM_Z: imm32 = {27'b0, instr[12:8]};
`endif
            default: illegal = 1'b1;
        endcase
    end

    // zimm has a clear top bit, so one sign-extension covers every encoding
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate extender between decode and execute with a 2-entry
// skid buffer and flush. Optional macro: IMM_EXTEND_ZIMM_EN (see imm_decode).
//
//   state | meaning
//   EMPTY | no entries held
//   ONE   | main holds the presented entry
//   TWO   | main + skid full, in_ready low
module imm_extend_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    logic [XLEN-1:0]  dec_imm;
    logic             dec_ill;
    stage_state_t     state, state_nxt;
    logic [XLEN-1:0]  main_imm, skid_imm;
    logic [TAG_W-1:0] main_tag, skid_tag;
    logic             main_ill, skid_ill;
    logic             accept, retire;
    logic             load_main_in, load_main_skid, load_skid;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .immsrc  (in_immsrc),
        .imm     (dec_imm),
        .illegal (dec_ill)
    );

    assign in_ready  = (state != TWO) && !reset;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && retire) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (retire) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (retire) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // a flushed accept is simply never stored
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_imm <= '0;
            main_tag <= '0;
            main_ill <= 1'b0;
            skid_imm <= '0;
            skid_tag <= '0;
            skid_ill <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_imm <= dec_imm;
                main_tag <= in_tag;
                main_ill <= dec_ill;
            end else if (load_main_skid) begin
                main_imm <= skid_imm;
                main_tag <= skid_tag;
                main_ill <= skid_ill;
            end
            if (load_skid) begin
                skid_imm <= dec_imm;
                skid_tag <= in_tag;
                skid_ill <= dec_ill;
            end
        end
    end

    assign out_imm     = main_imm;
    assign out_tag     = main_tag;
    assign out_illegal = main_ill;

endmodule
